// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_if
// Purpose  : Program-load and instruction-delivery bundle of the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_fetch_if #(
   parameter int INSTR_WIDTH = 20,
   parameter int ADDR_BITS   = 5
);
   logic                   prog_we;
   logic [ADDR_BITS-1:0]   prog_addr;
   logic [INSTR_WIDTH-1:0] prog_data;
   logic [INSTR_WIDTH-1:0] instr;
   logic [ADDR_BITS-1:0]   pc;
   logic                   fetch_strobe;
   logic                   done;

   modport master (
      output prog_we, prog_addr, prog_data,
      input  instr, pc, fetch_strobe, done
   );

   modport slave (
      input  prog_we, prog_addr, prog_data,
      output instr, pc, fetch_strobe, done
   );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : Loadable instruction memory + PC; holds each word for the CU's
//            dwell on its class. Option macro: FETCH_WRAP_EN (wrap at end).
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
   parameter int INSTR_WIDTH = 20,
   parameter int ADDR_BITS   = 5
) (
   input  logic         clk,
   input  logic         rst,
   instr_fetch_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_BITS;

   localparam logic [1:0] F_RESET = 2'd0;
   localparam logic [1:0] F_SKIP  = 2'd1;
   localparam logic [1:0] F_HOLD  = 2'd2;
   localparam logic [1:0] F_DONE  = 2'd3;

   localparam logic [1:0] CLS_NOP = 2'b00;
   localparam logic [1:0] CLS_STD = 2'b01;

   localparam logic [ADDR_BITS-1:0] LAST_ADDR = {ADDR_BITS{1'b1}};

`ifdef FETCH_WRAP_EN
   localparam bit STOP_AT_END = 1'b0;
`else
   localparam bit STOP_AT_END = 1'b1;
`endif

   logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

   logic [1:0]             state_q,  state_d;
   logic [INSTR_WIDTH-1:0] instr_q,  instr_d;
   logic [ADDR_BITS-1:0]   pc_q,     pc_d;
   logic                   strobe_q, strobe_d;
   logic                   done_q,   done_d;
   logic [1:0]             cnt_q,    cnt_d;

   logic [ADDR_BITS-1:0]   w_next_addr;
   logic [INSTR_WIDTH-1:0] w_next_word;
   logic                   w_at_end;

   // Counter preload is dwell-1: the fetch fires on the edge where it reads 0.
   function automatic logic [1:0] dwell_m1(input logic [1:0] cls);
      return (cls == CLS_STD) ? 2'd2 : 2'd3;
   endfunction

   assign w_next_addr = pc_q + ADDR_BITS'(1);
   assign w_next_word = mem_q[w_next_addr];
   assign w_at_end    = STOP_AT_END && (pc_q == LAST_ADDR);

   always_ff @(posedge clk) begin
      if (!rst && bus.prog_we) begin
         mem_q[bus.prog_addr] <= bus.prog_data;
      end
   end

   always_comb begin
      state_d  = state_q;
      instr_d  = instr_q;
      pc_d     = pc_q;
      strobe_d = 1'b0;
      done_d   = done_q;
      cnt_d    = cnt_q;
      case (state_q)
         F_RESET: begin
            instr_d  = mem_q[0];
            pc_d     = '0;
            strobe_d = 1'b1;
            state_d  = F_SKIP;
         end
         F_SKIP: begin
            if (instr_q[INSTR_WIDTH-1 -: 2] != CLS_NOP) begin
               // Loading here, one edge after the word appeared, adds the CU's RESET->DECODE cycle.
               cnt_d   = dwell_m1(instr_q[INSTR_WIDTH-1 -: 2]);
               state_d = F_HOLD;
            end else if (w_at_end) begin
               instr_d = '0;
               done_d  = 1'b1;
               state_d = F_DONE;
            end else begin
               instr_d  = w_next_word;
               pc_d     = w_next_addr;
               strobe_d = 1'b1;
            end
         end
         F_HOLD: begin
            if (cnt_q != 2'd0) begin
               cnt_d = cnt_q - 2'd1;
            end else if (w_at_end) begin
               instr_d = '0;
               done_d  = 1'b1;
               state_d = F_DONE;
            end else begin
               instr_d  = w_next_word;
               pc_d     = w_next_addr;
               strobe_d = 1'b1;
               cnt_d    = dwell_m1(w_next_word[INSTR_WIDTH-1 -: 2]);
            end
         end
         default: begin
            state_d = F_DONE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= F_RESET;
         instr_q  <= '0;
         pc_q     <= '0;
         strobe_q <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         instr_q  <= instr_d;
         pc_q     <= pc_d;
         strobe_q <= strobe_d;
         done_q   <= done_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.instr        = instr_q;
   assign bus.pc           = pc_q;
   assign bus.fetch_strobe = strobe_q;
`ifdef FETCH_WRAP_EN
   assign bus.done         = 1'b0;
`else
   assign bus.done         = done_q;
`endif
endmodule
`default_nettype wire
